regfile_wr_arbiter: RTL

- Shares the single write port of the processor register file between NREQ requesters, e.g. ALU write-back, load write-back and a debug port.
- The register file is a bank of enable/clear flip-flop registers. This block drives their per-register enables (one-hot), the shared write data and the write address.
- Arbitration is round-robin with a valid/ready handshake. The write stage is registered, so writes reach the bank one cycle after the handshake.

---
 rtl/regfile_wr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing the register-file write port.
// Requesters handshake with valid/ready. The accepted write is registered and
// presented to the register bank one cycle later as one-hot enables + data.
module regfile_wr_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16,
  localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREG-1:0]          wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     wr_valid,
  output logic [GW-1:0]            grant_id,
  output logic [CNT_W-1:0]         wr_count
);

  // Unpacked views of the per-requester address and data buses.
  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Registered state.
  logic [GW-1:0]     ptr_reg;
  logic              wr_valid_reg;
  logic [NREG-1:0]   wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [GW-1:0]     grant_id_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  // Arbitration results.
  logic              win_found;
  logic [GW-1:0]     win_idx;
  logic [GW:0]       scan_idx;
  logic              transfer;
  logic [GW-1:0]     ptr_next;
  logic [ADDR_W-1:0] win_addr;
  logic [NREG-1:0]   win_dec;

  // Scan requesters starting at ptr, wrapping modulo NREQ; first valid wins.
  // The extra bit on scan_idx lets the wrap work for non-power-of-2 NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_reg} + (GW+1)'(k);
      if (scan_idx >= (GW+1)'(NREQ)) begin
        scan_idx = scan_idx - (GW+1)'(NREQ);
      end
      if (!win_found && req_valid[scan_idx[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[GW-1:0];
      end
    end
  end

  // A transfer needs a winner, no stall, and reset released.
  assign transfer = win_found && !hold && clr_n;

  // Ready goes to the winner only; all low under hold or reset.
  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Pointer advances past the requester that just transferred.
  always_comb begin
    ptr_next = ptr_reg;
    if (transfer) begin
      if (win_idx == GW'(NREQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = win_idx + GW'(1);
      end
    end
  end

  assign win_addr = addr_arr[win_idx];

  // One-hot decode of the winning address; register 0 is hardwired zero
  // so its enable is never driven.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
    if (gi == 0) begin : g_zero
      assign win_dec[gi] = 1'b0;
    end else begin : g_reg
      assign win_dec[gi] = (win_addr == ADDR_W'(gi));
    end
  end

  // Write stage and arbitration state; reset discards any pending write.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ptr_reg      <= '0;
      wr_valid_reg <= 1'b0;
      wr_en_reg    <= '0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      grant_id_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      wr_valid_reg <= transfer;
      wr_en_reg    <= transfer ? win_dec : '0;
      if (transfer) begin
        wr_addr_reg  <= win_addr;
        wr_data_reg  <= data_arr[win_idx];
        grant_id_reg <= win_idx;
        wr_count_reg <= wr_count_reg + CNT_W'(1);
      end
    end
  end

  assign wr_valid = wr_valid_reg;
  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign grant_id = grant_id_reg;
  assign wr_count = wr_count_reg;

endmodule
